// File: rtl/rtc_pkg.sv
// Shared constants, BCD field layout and load-FSM encoding for the BCD real-time clock.
package rtc_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned TIME_W  = 24;

    localparam int unsigned SEC_U_LSB = 0;
    localparam int unsigned SEC_T_LSB = 4;
    localparam int unsigned MIN_U_LSB = 8;
    localparam int unsigned MIN_T_LSB = 12;
    localparam int unsigned HR_U_LSB  = 16;
    localparam int unsigned HR_T_LSB  = 20;

    localparam logic [DIGIT_W-1:0] UNITS_MAX    = 4'd9;
    localparam logic [DIGIT_W-1:0] TENS_MAX     = 4'd5;
    localparam logic [DIGIT_W-1:0] HR_T_MAX     = 4'd2;
    localparam logic [DIGIT_W-1:0] HR_U_MAX_TOP = 4'd3;  // hour units limit when tens == 2

    localparam logic [TIME_W-1:0] TIME_ZERO = '0;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StCommit
    } load_state_e;

    function automatic logic time_valid(input logic [TIME_W-1:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (t[i*DIGIT_W +: DIGIT_W] > UNITS_MAX) ok = 1'b0;
        end
        if (t[SEC_T_LSB +: DIGIT_W] > TENS_MAX) ok = 1'b0;
        if (t[MIN_T_LSB +: DIGIT_W] > TENS_MAX) ok = 1'b0;
        if (t[HR_T_LSB +: DIGIT_W] > HR_T_MAX) ok = 1'b0;
        if (t[HR_T_LSB +: DIGIT_W] == HR_T_MAX && t[HR_U_LSB +: DIGIT_W] > HR_U_MAX_TOP) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/rtc_bcd_if.sv
// Time-load request bus: requester drives set_valid/set_time, clock returns ready and error.
interface rtc_bcd_if;
    import rtc_pkg::*;

    logic              set_valid;
    logic [TIME_W-1:0] set_time;
    logic              set_ready;
    logic              set_err;

    modport master (
        output set_valid,
        output set_time,
        input  set_ready,
        input  set_err
    );

    modport slave (
        input  set_valid,
        input  set_time,
        output set_ready,
        output set_err
    );

endinterface

// File: rtl/bcd_digit_counter.sv
// Single modulo-(Max+1) BCD digit with clear, parallel load, increment-in and carry-out.
module bcd_digit_counter
    import rtc_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] Max = UNITS_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic [DIGIT_W-1:0] q_next,
    output logic               carry
);

    always_comb begin
        q_next = q;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = load_val;
        end else if (inc) begin
            q_next = (q == Max) ? '0 : q + 4'd1;
        end
    end

    assign carry = inc && (q == Max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/rtc_bcd.sv
// HH:MM:SS BCD clock advanced by pps, with a validated load port, alarm compare and pps watchdog.
module rtc_bcd
    import rtc_pkg::*;
#(
    parameter int unsigned PPS_TIMEOUT = 60_000_000
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    rtc_bcd_if.slave          set_bus,
    input  logic              pps,
    input  logic              alarm_en,
    input  logic [TIME_W-1:0] alarm_time,
    output logic [TIME_W-1:0] time_bcd,
    output logic              tick,
    output logic              day_wrap,
    output logic              alarm,
    output logic              pps_lost
);

    localparam int unsigned WdW = $clog2(PPS_TIMEOUT + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(PPS_TIMEOUT);

    load_state_e       state_q, state_d;
    logic [TIME_W-1:0] cap_q;
    logic              cap_ok_q;
    logic              commit_load, commit_err, inc_en;
    logic              set_ready_q, set_err_q, tick_q, day_wrap_q, alarm_q, pps_lost_q;
    logic [WdW-1:0]    wd_q, wd_d;

    logic [DIGIT_W-1:0] sec_u, sec_t, min_u, min_t, hr_u, hr_t;
    logic [DIGIT_W-1:0] sec_u_nx, sec_t_nx, min_u_nx, min_t_nx, hr_u_nx, hr_t_nx;
    logic               sec_u_c, sec_t_c, min_u_c, min_t_c, hr_u_c, hr_t_c;
    logic               hour_wrap;
    logic [TIME_W-1:0]  time_nx;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (set_bus.set_valid) state_d = StCheck;
            StCheck:  state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign commit_load = (state_q == StCommit) && cap_ok_q;
    assign commit_err  = (state_q == StCommit) && !cap_ok_q;
    // A valid load owns the digits this cycle, so a coincident pps is dropped.
    assign inc_en      = pps && !commit_load;

    // 23 -> 00 is decided here because the hour digits do not wrap at their own limits.
    assign hour_wrap = min_t_c && (hr_t == HR_T_MAX) && (hr_u == HR_U_MAX_TOP);

    bcd_digit_counter #(.Max(UNITS_MAX)) u_sec_u (
        .clk(clk_50m), .rst_n(rst_n), .clr(1'b0), .load(commit_load),
        .load_val(cap_q[SEC_U_LSB +: DIGIT_W]), .inc(inc_en),
        .q(sec_u), .q_next(sec_u_nx), .carry(sec_u_c)
    );
    bcd_digit_counter #(.Max(TENS_MAX)) u_sec_t (
        .clk(clk_50m), .rst_n(rst_n), .clr(1'b0), .load(commit_load),
        .load_val(cap_q[SEC_T_LSB +: DIGIT_W]), .inc(sec_u_c),
        .q(sec_t), .q_next(sec_t_nx), .carry(sec_t_c)
    );
    bcd_digit_counter #(.Max(UNITS_MAX)) u_min_u (
        .clk(clk_50m), .rst_n(rst_n), .clr(1'b0), .load(commit_load),
        .load_val(cap_q[MIN_U_LSB +: DIGIT_W]), .inc(sec_t_c),
        .q(min_u), .q_next(min_u_nx), .carry(min_u_c)
    );
    bcd_digit_counter #(.Max(TENS_MAX)) u_min_t (
        .clk(clk_50m), .rst_n(rst_n), .clr(1'b0), .load(commit_load),
        .load_val(cap_q[MIN_T_LSB +: DIGIT_W]), .inc(min_u_c),
        .q(min_t), .q_next(min_t_nx), .carry(min_t_c)
    );
    bcd_digit_counter #(.Max(UNITS_MAX)) u_hr_u (
        .clk(clk_50m), .rst_n(rst_n), .clr(hour_wrap), .load(commit_load),
        .load_val(cap_q[HR_U_LSB +: DIGIT_W]), .inc(min_t_c && !hour_wrap),
        .q(hr_u), .q_next(hr_u_nx), .carry(hr_u_c)
    );
    bcd_digit_counter #(.Max(HR_T_MAX)) u_hr_t (
        .clk(clk_50m), .rst_n(rst_n), .clr(hour_wrap), .load(commit_load),
        .load_val(cap_q[HR_T_LSB +: DIGIT_W]), .inc(hr_u_c),
        .q(hr_t), .q_next(hr_t_nx), .carry(hr_t_c)
    );

    // Hour tens can never carry: the day wraps at 23 before tens could pass 2.
    assert property (@(posedge clk_50m) disable iff (!rst_n) !hr_t_c);

    assign time_nx = {hr_t_nx, hr_u_nx, min_t_nx, min_u_nx, sec_t_nx, sec_u_nx};

    always_comb begin
        wd_d = wd_q;
        if (pps) begin
            wd_d = '0;
        end else if (wd_q < WdMax) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cap_q       <= TIME_ZERO;
            cap_ok_q    <= 1'b0;
            set_ready_q <= 1'b1;
            set_err_q   <= 1'b0;
            tick_q      <= 1'b0;
            day_wrap_q  <= 1'b0;
            alarm_q     <= 1'b0;
            wd_q        <= '0;
            pps_lost_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (state_q == StIdle && set_bus.set_valid) cap_q <= set_bus.set_time;
            if (state_q == StCheck) cap_ok_q <= time_valid(cap_q);
            set_ready_q <= (state_d == StIdle);
            set_err_q   <= commit_err;
            tick_q      <= inc_en;
            day_wrap_q  <= hour_wrap;
            alarm_q     <= inc_en && alarm_en && (time_nx == alarm_time);
            wd_q        <= wd_d;
            if (pps) begin
                pps_lost_q <= 1'b0;
            end else if (wd_d == WdMax) begin
                pps_lost_q <= 1'b1;
            end
        end
    end

    assign time_bcd          = {hr_t, hr_u, min_t, min_u, sec_t, sec_u};
    assign tick              = tick_q;
    assign day_wrap          = day_wrap_q;
    assign alarm             = alarm_q;
    assign pps_lost          = pps_lost_q;
    assign set_bus.set_ready = set_ready_q;
    assign set_bus.set_err   = set_err_q;

endmodule

// File: tb/tb_rtc_bcd.sv
// Scoreboard bench for rtc_bcd: a seconds-of-day model predicts every tick/error event.
module tb_rtc_bcd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pps = 1'b0;
    logic        alarm_en = 1'b0;
    logic [23:0] alarm_time = '0;
    logic [23:0] time_bcd;
    logic        tick, day_wrap, alarm, pps_lost;

    rtc_bcd_if bus ();

    rtc_bcd #(.PPS_TIMEOUT(100)) dut (
        .clk_50m   (clk),
        .rst_n     (rst_n),
        .set_bus   (bus),
        .pps       (pps),
        .alarm_en  (alarm_en),
        .alarm_time(alarm_time),
        .time_bcd  (time_bcd),
        .tick      (tick),
        .day_wrap  (day_wrap),
        .alarm     (alarm),
        .pps_lost  (pps_lost)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic        tick;
        logic        err;
        logic        wrap;
        logic        alm;
        logic [23:0] t;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  model_sec = 0;

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, c;
        h = s / 3600;
        m = (s / 60) % 60;
        c = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic bit bcd_ok(input logic [23:0] t);
        int h;
        for (int i = 0; i < 6; i++) begin
            if (t[i*4 +: 4] > 9) return 1'b0;
        end
        if (t[15:12] > 5 || t[7:4] > 5) return 1'b0;
        h = 10 * int'(t[23:20]) + int'(t[19:16]);
        return h <= 23;
    endfunction

    function automatic int from_bcd(input logic [23:0] t);
        return (10 * int'(t[23:20]) + int'(t[19:16])) * 3600
             + (10 * int'(t[15:12]) + int'(t[11:8])) * 60
             + (10 * int'(t[7:4]) + int'(t[3:0]));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle the DUT flags an event, it must match the oldest prediction.
    initial begin
        ev_t a;
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (tick || bus.set_err || day_wrap || alarm)) begin
                a = '{tick: tick, err: bus.set_err, wrap: day_wrap, alm: alarm, t: time_bcd};
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: got %h, expected no event at %0t", a, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("event", 32'(a), 32'(e));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ev_t predict_tick(input bit err);
        ev_t e;
        model_sec = (model_sec + 1) % 86400;
        e.tick = 1'b1;
        e.err  = err;
        e.wrap = (model_sec == 0);
        e.alm  = alarm_en && (to_bcd(model_sec) == alarm_time);
        e.t    = to_bcd(model_sec);
        return e;
    endfunction

    task automatic pulse_pps();
        pps = 1'b1;
        exp_q.push_back(predict_tick(1'b0));
        step();
        pps = 1'b0;
        step();
    endtask

    task automatic load(input logic [23:0] t, input bit with_pps);
        ev_t e;
        bus.set_valid = 1'b1;
        bus.set_time  = t;
        step();
        bus.set_valid = 1'b0;
        check("ready_busy", 32'(bus.set_ready), 32'd0);
        step();
        pps = with_pps;
        if (bcd_ok(t)) begin
            model_sec = from_bcd(t);
        end else if (with_pps) begin
            exp_q.push_back(predict_tick(1'b1));
        end else begin
            e = '{tick: 1'b0, err: 1'b1, wrap: 1'b0, alm: 1'b0, t: to_bcd(model_sec)};
            exp_q.push_back(e);
        end
        step();
        pps = 1'b0;
        check("time_after_load", 32'(time_bcd), 32'(to_bcd(model_sec)));
        check("ready_after_load", 32'(bus.set_ready), 32'd1);
        step();
    endtask

    task automatic check_reset_outputs();
        check("reset_outputs",
              32'({time_bcd, tick, day_wrap, alarm, bus.set_err, pps_lost, bus.set_ready}),
              32'({24'h000000, 5'b00000, 1'b1}));
    endtask

    task automatic do_reset();
        step();
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        step();
        rst_n = 1'b1;
        model_sec = 0;
    endtask

    initial begin
        bus.set_valid = 1'b0;
        bus.set_time  = '0;
        step();
        do_reset();

        pulse_pps();
        load(24'h123456, 1'b0);
        pulse_pps();
        load(24'h235959, 1'b0);
        pulse_pps();
        load(24'h236000, 1'b0);
        load(24'h240000, 1'b0);
        load(24'h095959, 1'b0);
        pulse_pps();
        load(24'h080000, 1'b1);
        load(24'h246000, 1'b1);

        // Alarm at 00:00:05, then the same run with the compare disabled.
        do_reset();
        alarm_en   = 1'b1;
        alarm_time = 24'h000005;
        repeat (5) begin
            pulse_pps();
            step();
        end
        do_reset();
        alarm_en = 1'b0;
        repeat (5) pulse_pps();

        // Reset landing while a load sits in CHECK.
        step();
        step();
        bus.set_valid = 1'b1;
        bus.set_time  = 24'h123456;
        step();
        bus.set_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        step();
        rst_n = 1'b1;
        model_sec = 0;
        repeat (4) step();
        check("time_after_abandoned_load", 32'(time_bcd), 32'h0);
        pulse_pps();

        // Watchdog: no pps for 100 cycles.
        do_reset();
        repeat (99) step();
        check("pps_lost_cycle99", 32'(pps_lost), 32'd0);
        step();
        check("pps_lost_cycle100", 32'(pps_lost), 32'd1);
        repeat (20) step();
        check("pps_lost_sticky", 32'(pps_lost), 32'd1);
        pps = 1'b1;
        exp_q.push_back(predict_tick(1'b0));
        step();
        pps = 1'b0;
        check("pps_lost_cleared", 32'(pps_lost), 32'd0);
        step();

        // Randomised mix of ticks, valid/invalid loads and alarm targets.
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 10) begin
                alarm_en   = 1'($urandom_range(0, 1));
                alarm_time = to_bcd((model_sec + int'($urandom_range(1, 3))) % 86400);
            end else if (r < 25) begin
                load(to_bcd(int'($urandom_range(0, 86399))), 1'($urandom_range(0, 1)));
            end else if (r < 33) begin
                load(24'($urandom), 1'($urandom_range(0, 1)));
            end else if (r < 38) begin
                load(to_bcd(86399 - int'($urandom_range(0, 3))), 1'b0);
            end else begin
                repeat ($urandom_range(0, 15)) step();
                pulse_pps();
            end
        end

        repeat (3) step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_pps_lost", 32'(pps_lost), 32'd0);
        check("final_time", 32'(time_bcd), 32'(to_bcd(model_sec)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
